rps_hand_encoder: RTL and testbench
===================================

RPS_HAND_ENCODER -- requirements
Module: rps_hand_encoder

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, clock cycles per countdown beat and length of the shoot window (legal range 2..255).
REQ-002 SHALL have parameter BEATS, default 3, number of countdown beats before the shoot window (legal range 1..3).
REQ-003 SHALL use hand codes ROCK 2'b00, PAPER 2'b01, SCISORS 2'b10 and INVALID 2'b11; INVALID is the code the downstream judge flags as an error.
REQ-004 SHALL have clk  input  1  the single clock; all state changes on the rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have start  input  1  request a new round; honoured only in IDLE.
REQ-007 SHALL have a_btn  input  3  player A buttons, {scisors, paper, rock}, level-sampled every cycle.
REQ-008 SHALL have b_btn  input  3  player B buttons, same encoding as a_btn.
REQ-009 SHALL have hand_ready  input  1  downstream accepts A/B when high with hand_valid.
REQ-010 SHALL have A  output  2  player A hand code.
REQ-011 SHALL have B  output  2  player B hand code.
REQ-012 SHALL have hand_valid  output  1  A/B hold a completed round.
REQ-013 SHALL have busy  output  1  high in every state except IDLE.
REQ-014 SHALL have beat  output  2  remaining countdown beats, for display.

Function
REQ-015 SHALL implement FSM states IDLE, COUNT, SHOOT, PRESENT.
REQ-016 IDLE: start=1 -> COUNT; beat loaded with BEATS; tick counter cleared; both foul flags cleared; both capture registers set to INVALID with captured flags cleared.
REQ-017 COUNT: tick counter increments each cycle; at TICK_DIV-1 it wraps to 0 and beat decrements; the wrap that takes beat from 1 to 0 moves to SHOOT.
REQ-018 COUNT: any nonzero button vector from a player sets that player's foul flag (early throw); the flag is sticky until the next start.
REQ-019 SHOOT: lasts exactly TICK_DIV cycles, with beat=0.
REQ-020 SHOOT: the first nonzero button vector from a non-fouled player is captured; one-hot is encoded to its hand code; multi-hot is encoded to INVALID.
REQ-021 SHOOT: once a player is captured, later presses from that player are ignored (first press wins); the two players are captured independently.
REQ-022 SHOOT end -> PRESENT; a fouled or uncaptured player presents INVALID.
REQ-023 PRESENT: hand_valid=1; A/B stay stable until hand_ready=1 is sampled; that cycle is the transfer, and the FSM moves to IDLE.
REQ-024 Latency: hand_valid SHALL rise exactly (BEATS+1)*TICK_DIV cycles after the edge that samples start (16 at defaults).
REQ-025 start SHALL be ignored in COUNT, SHOOT and PRESENT, including the transfer cycle; no request is queued.
REQ-026 A/B SHALL hold the last presented values outside PRESENT.
REQ-027 hand_ready outside PRESENT SHALL have no effect.
REQ-028 Buttons in IDLE and PRESENT SHALL be ignored.
REQ-029 A button held from COUNT into SHOOT SHALL count as a foul, not a capture.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, A=B=2'b11, hand_valid=0, busy=0, beat=0, counters=0 and flags=0, regardless of clock.
REQ-031 Reset asserted mid-round SHALL abort the round; no hand_valid is produced for it.
REQ-032 After rst_n deasserts, the first start SHALL be honoured on the next rising edge.

Verification
REQ-033 Defaults; start; a_btn=001 and b_btn=100 pressed 2 cycles into SHOOT -> hand_valid rises 16 cycles after start, A=00, B=10, held until hand_ready.
REQ-034 a_btn=010 during COUNT, then a_btn=001 in SHOOT; b_btn=010 in SHOOT -> A=11 (foul), B=01.
REQ-035 No presses at all -> A=11, B=11, hand_valid at cycle 16.
REQ-036 a_btn=011 in SHOOT, then 001 -> A=11 (first press multi-hot wins); b_btn=100 then 001 -> B=10.
REQ-037 hand_ready held low 5 cycles in PRESENT with start pulsed -> A/B/hand_valid stable; start ignored; IDLE after the transfer.
REQ-038 rst_n pulsed low in the middle of SHOOT -> outputs at reset values immediately; no hand_valid follows until a new start.

Source files
------------

// File: rtl/rps_hand_encoder.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : rps_hand_encoder
// Purpose  : Rock-paper-scissors round sequencer. On start it runs a visible
//            countdown of BEATS beats (TICK_DIV cycles each), then opens a
//            shoot window of TICK_DIV cycles in which each player's first
//            button press is captured and encoded. The two hand codes are
//            then presented to a downstream judge with a valid/ready
//            handshake.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk        in   1  clock, rising edge active
//   rst_n      in   1  asynchronous active-low reset
//   start      in   1  request a new round (honoured only when idle)
//   a_btn      in   3  player A buttons {scissors, paper, rock}
//   b_btn      in   3  player B buttons, same encoding
//   hand_ready in   1  downstream accepts A/B while hand_valid is high
//   A          out  2  player A hand code
//   B          out  2  player B hand code
//   hand_valid out  1  A/B hold a completed round
//   busy       out  1  high whenever a round is in progress or presented
//   beat       out  2  remaining countdown beats, for display
//
// Hand codes: ROCK 2'b00, PAPER 2'b01, SCISSORS 2'b10, INVALID 2'b11.
//----------------------------------------------------------------------------
module rps_hand_encoder #(
  parameter int TICK_DIV = 4,   // cycles per beat and shoot-window length, 2..255
  parameter int BEATS    = 3    // countdown beats before the shoot window, 1..3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] a_btn,
  input  logic [2:0] b_btn,
  input  logic       hand_ready,
  output logic [1:0] A,
  output logic [1:0] B,
  output logic       hand_valid,
  output logic       busy,
  output logic [1:0] beat
);

  //--------------------------------------------------------------------------
  // Constants
  //--------------------------------------------------------------------------
  localparam logic [1:0] C_ROCK     = 2'b00;
  localparam logic [1:0] C_PAPER    = 2'b01;
  localparam logic [1:0] C_SCISSORS = 2'b10;
  localparam logic [1:0] C_INVALID  = 2'b11;

  localparam logic [7:0] C_TICK_LAST = 8'(TICK_DIV - 1);
  localparam logic [1:0] C_BEATS     = 2'(BEATS);

  //--------------------------------------------------------------------------
  // State encoding
  //--------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_SHOOT   = 2'd2,
    ST_PRESENT = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  // Countdown / window timing
  logic [7:0] r_tick;
  logic [1:0] r_beat;
  logic       w_tick_wrap;

  // Per-player round bookkeeping
  logic       r_foul_a;
  logic       r_foul_b;
  logic       r_cap_a;
  logic       r_cap_b;
  logic [1:0] r_code_a;
  logic [1:0] r_code_b;

  // Capture decision for the current cycle
  logic       w_take_a;
  logic       w_take_b;
  logic       w_cap_a_next;
  logic       w_cap_b_next;
  logic [1:0] w_code_a_next;
  logic [1:0] w_code_b_next;
  logic [1:0] w_final_a;
  logic [1:0] w_final_b;

  //--------------------------------------------------------------------------
  // One-hot button vector to hand code. Anything other than exactly one
  // button (multi-hot) maps to INVALID so the judge can flag it.
  //--------------------------------------------------------------------------
  function automatic logic [1:0] encode_hand(input logic [2:0] btn);
    logic [1:0] code;
    case (btn)
      3'b001:  code = C_ROCK;
      3'b010:  code = C_PAPER;
      3'b100:  code = C_SCISSORS;
      default: code = C_INVALID;
    endcase
    return code;
  endfunction

  //--------------------------------------------------------------------------
  // Timing and capture decisions
  //--------------------------------------------------------------------------
  assign w_tick_wrap = (r_tick == C_TICK_LAST);

  // A player is captured on its first nonzero vector in the shoot window,
  // provided it did not throw early. Later presses never overwrite.
  assign w_take_a = (r_state == ST_SHOOT) && !r_foul_a && !r_cap_a && (|a_btn);
  assign w_take_b = (r_state == ST_SHOOT) && !r_foul_b && !r_cap_b && (|b_btn);

  assign w_cap_a_next  = r_cap_a | w_take_a;
  assign w_cap_b_next  = r_cap_b | w_take_b;
  assign w_code_a_next = w_take_a ? encode_hand(a_btn) : r_code_a;
  assign w_code_b_next = w_take_b ? encode_hand(b_btn) : r_code_b;

  // The presented value folds in a press on the very last window cycle, so
  // the window really is TICK_DIV cycles long.
  assign w_final_a = (r_foul_a || !w_cap_a_next) ? C_INVALID : w_code_a_next;
  assign w_final_b = (r_foul_b || !w_cap_b_next) ? C_INVALID : w_code_b_next;

  //--------------------------------------------------------------------------
  // FSM state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  //--------------------------------------------------------------------------
  // FSM next state and status outputs
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    hand_valid   = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = ST_COUNT;
        end
      end
      ST_COUNT: begin
        // Leave on the wrap that consumes the final beat.
        if (w_tick_wrap && (r_beat == 2'd1)) begin
          w_state_next = ST_SHOOT;
        end
      end
      ST_SHOOT: begin
        if (w_tick_wrap) begin
          w_state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        hand_valid = 1'b1;
        if (hand_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Round datapath: counters, foul flags, captures and presented codes.
  // A/B are only written at the end of the shoot window, so they keep the
  // last presented round in every other state.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick   <= 8'd0;
      r_beat   <= 2'd0;
      r_foul_a <= 1'b0;
      r_foul_b <= 1'b0;
      r_cap_a  <= 1'b0;
      r_cap_b  <= 1'b0;
      r_code_a <= C_INVALID;
      r_code_b <= C_INVALID;
      A        <= C_INVALID;
      B        <= C_INVALID;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_tick   <= 8'd0;
            r_beat   <= C_BEATS;
            r_foul_a <= 1'b0;
            r_foul_b <= 1'b0;
            r_cap_a  <= 1'b0;
            r_cap_b  <= 1'b0;
            r_code_a <= C_INVALID;
            r_code_b <= C_INVALID;
          end
        end
        ST_COUNT: begin
          r_tick <= w_tick_wrap ? 8'd0 : r_tick + 8'd1;
          if (w_tick_wrap) begin
            r_beat <= r_beat - 2'd1;
          end
          // Any press before the window is an early throw. A button still
          // held when the window opens was already flagged here, so it can
          // never turn into a capture.
          if (|a_btn) begin
            r_foul_a <= 1'b1;
          end
          if (|b_btn) begin
            r_foul_b <= 1'b1;
          end
        end
        ST_SHOOT: begin
          r_tick   <= w_tick_wrap ? 8'd0 : r_tick + 8'd1;
          r_cap_a  <= w_cap_a_next;
          r_cap_b  <= w_cap_b_next;
          r_code_a <= w_code_a_next;
          r_code_b <= w_code_b_next;
          if (w_tick_wrap) begin
            A <= w_final_a;
            B <= w_final_b;
          end
        end
        default: begin
          // PRESENT: everything holds until the transfer.
        end
      endcase
    end
  end

  assign beat = r_beat;

endmodule
`default_nettype wire

// File: tb/tb_rps_hand_encoder.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : tb_rps_hand_encoder
// Purpose  : Self-checking bench for rps_hand_encoder at default parameters.
//            Directed rounds push their hand-computed A/B pair into a queue;
//            a monitor pops and compares on every handshake transfer.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
module tb_rps_hand_encoder;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic       start      = 1'b0;
  logic       hand_ready = 1'b0;
  logic [2:0] a_btn      = 3'b000;
  logic [2:0] b_btn      = 3'b000;
  logic [1:0] A;
  logic [1:0] B;
  logic       hand_valid;
  logic       busy;
  logic [1:0] beat;

  int checks = 0;
  int errors = 0;

  // Expected {A, B} per presented round
  logic [3:0] exp_q[$];
  logic [3:0] mon_e;

  // Button vectors applied before rising edges 1..16 after the start edge
  logic [2:0] a_seq[16];
  logic [2:0] b_seq[16];

  rps_hand_encoder #(
    .TICK_DIV (4),
    .BEATS    (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_btn      (a_btn),
    .b_btn      (b_btn),
    .hand_ready (hand_ready),
    .A          (A),
    .B          (B),
    .hand_valid (hand_valid),
    .busy       (busy),
    .beat       (beat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted transfer must match the oldest expected round.
  always @(negedge clk) begin
    if (rst_n && hand_valid && hand_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected actual=%0d%0d required=none", A, B);
      end else begin
        mon_e = exp_q.pop_front();
        chk("xfer_A", int'(A), int'(mon_e[3:2]));
        chk("xfer_B", int'(B), int'(mon_e[1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_seq();
    for (int i = 0; i < 16; i++) begin
      a_seq[i] = 3'b000;
      b_seq[i] = 3'b000;
    end
  endtask

  // Start a round and step through countdown and shoot window, checking
  // latency, beat display and busy each cycle.
  task automatic run_round(input string tag);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      a_btn = a_seq[k-1];
      b_btn = b_seq[k-1];
      @(posedge clk);
      #1;
      chk({tag, "_valid"}, int'(hand_valid), (k == 16) ? 1 : 0);
      chk({tag, "_beat"}, int'(beat), (k >= 12) ? 0 : 3 - k / 4);
      chk({tag, "_busy"}, int'(busy), 1);
    end
    a_btn = 3'b000;
    b_btn = 3'b000;
  endtask

  // Hold hand_ready low for n cycles (optionally poking start/buttons),
  // then complete the transfer.
  task automatic present_phase(input string tag, input int n,
                               input logic [1:0] ea, input logic [1:0] eb,
                               input bit poke);
    for (int i = 0; i < n; i++) begin
      if (poke) begin
        start = (i == 2);
        a_btn = 3'b111;
        b_btn = 3'b010;
      end
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, int'(hand_valid), 1);
      chk({tag, "_hold_A"}, int'(A), int'(ea));
      chk({tag, "_hold_B"}, int'(B), int'(eb));
    end
    start      = poke;
    hand_ready = 1'b1;
    @(posedge clk);
    #1;
    hand_ready = 1'b0;
    start      = 1'b0;
    a_btn      = 3'b000;
    b_btn      = 3'b000;
    chk({tag, "_post_valid"}, int'(hand_valid), 0);
    chk({tag, "_post_busy"}, int'(busy), 0);
    chk({tag, "_post_A"}, int'(A), int'(ea));
    chk({tag, "_post_B"}, int'(B), int'(eb));
    @(posedge clk);
    #1;
    chk({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    // Asynchronous reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_A", int'(A), 3);
    chk("rst_B", int'(B), 3);
    chk("rst_valid", int'(hand_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_beat", int'(beat), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Presses two cycles into the window; long PRESENT with start pokes
    clear_seq();
    a_seq[14] = 3'b001; a_seq[15] = 3'b001;
    b_seq[14] = 3'b100; b_seq[15] = 3'b100;
    exp_q.push_back({2'b00, 2'b10});
    run_round("basic");
    present_phase("basic", 5, 2'b00, 2'b10, 1'b1);

    // Early throw by A, normal B
    clear_seq();
    a_seq[5] = 3'b010; a_seq[13] = 3'b001;
    b_seq[13] = 3'b010;
    exp_q.push_back({2'b11, 2'b01});
    run_round("foul");
    present_phase("foul", 1, 2'b11, 2'b01, 1'b0);

    // No presses; hand_ready held high through the whole round
    clear_seq();
    hand_ready = 1'b1;
    exp_q.push_back({2'b11, 2'b11});
    run_round("none");
    present_phase("none", 0, 2'b11, 2'b11, 1'b0);

    // First press wins, including a multi-hot first press
    clear_seq();
    a_seq[12] = 3'b011; a_seq[13] = 3'b001;
    b_seq[12] = 3'b100; b_seq[13] = 3'b001;
    exp_q.push_back({2'b11, 2'b10});
    run_round("first");
    present_phase("first", 2, 2'b11, 2'b10, 1'b0);

    // A held from COUNT into SHOOT is a foul; B on first window cycle
    clear_seq();
    for (int i = 11; i < 16; i++) a_seq[i] = 3'b001;
    b_seq[12] = 3'b001;
    exp_q.push_back({2'b11, 2'b00});
    run_round("held");
    present_phase("held", 1, 2'b11, 2'b00, 1'b0);

    // A on last window cycle; B on last countdown cycle (foul)
    clear_seq();
    a_seq[15] = 3'b010;
    b_seq[11] = 3'b001;
    exp_q.push_back({2'b01, 2'b11});
    run_round("edges");
    present_phase("edges", 1, 2'b01, 2'b11, 1'b0);

    // Reset in the middle of the shoot window aborts the round
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (13) @(posedge clk);
    #1 a_btn = 3'b001;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_A", int'(A), 3);
    chk("midrst_B", int'(B), 3);
    chk("midrst_valid", int'(hand_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_beat", int'(beat), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_btn = 3'b000;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_novalid", int'(hand_valid), 0);
    end
    chk("midrst_idle", int'(busy), 0);

    // A fresh round after the aborted one
    clear_seq();
    a_seq[13] = 3'b100;
    b_seq[14] = 3'b010;
    exp_q.push_back({2'b10, 2'b01});
    run_round("after");
    present_phase("after", 2, 2'b10, 2'b01, 1'b0);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
